// File: rtl/video_frame_ctrl.sv
// video_frame_ctrl: HDMI timing tracker. It delays de/hs/vs by one cycle and
// produces pixel coordinates, line/frame strobes, and the measured resolution.
// A lock FSM confirms a stable resolution across frames. Processing-mode
// changes are held back until a frame boundary so the datapath never switches
// mid-frame.
module video_frame_ctrl #(
  parameter int X_W     = 11,
  parameter int Y_W     = 11,
  parameter int TIMEOUT = 2000000,
  parameter int VS_POL  = 1
) (
  input  logic           hdmi_clk,
  input  logic           rst,
  input  logic           in_de,
  input  logic           in_hs,
  input  logic           in_vs,
  input  logic [1:0]     mode_req,
  input  logic           mode_req_valid,
  output logic           out_de,
  output logic           out_hs,
  output logic           out_vs,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           frame_start,
  output logic           line_start,
  output logic [X_W-1:0] width,
  output logic [Y_W-1:0] height,
  output logic           locked,
  output logic [1:0]     sel,
  output logic           mode_ack
);

  localparam int   WD_W   = $clog2(TIMEOUT + 1);
  localparam logic VS_ACT = (VS_POL != 0);

  typedef enum logic [1:0] {
    ST_LOST    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_CONFIRM = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             de_q, hs_q, vs_q;
  logic             de_d, hs_d, vs_d;
  logic             vs_int_q, vs_int_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [X_W-1:0]   line_w_q, line_w_d;
  logic [X_W-1:0]   width_q, width_d;
  logic [Y_W-1:0]   height_q, height_d;
  logic [X_W-1:0]   ref_w_q, ref_w_d;
  logic [Y_W-1:0]   ref_h_q, ref_h_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             sync_q, sync_d;
  logic             fs_pend_q, fs_pend_d;
  logic             fs_q, fs_d;
  logic             ls_q, ls_d;
  logic             pend_q, pend_d;
  logic [1:0]       pend_mode_q, pend_mode_d;
  logic [1:0]       mode_q, mode_d;
  logic             ack_q, ack_d;

  logic             vs_int, vs_rise, de_rise, de_fall, wd_expired, dims_match;
  logic [X_W-1:0]   x_len;

  // Next-state logic for counters, strobes, lock FSM, watchdog and mode hand-off
  always_comb begin
    vs_int     = (in_vs == VS_ACT);
    vs_rise    = vs_int & ~vs_int_q;
    de_rise    = in_de & ~de_q;
    de_fall    = ~in_de & de_q;
    x_len      = (x_q == '1) ? x_q : x_q + 1'b1;
    wd_expired = (wd_q == WD_W'(TIMEOUT));
    dims_match = (line_w_q == ref_w_q) && (y_q == ref_h_q);

    de_d        = in_de;
    hs_d        = in_hs;
    vs_d        = in_vs;
    vs_int_d    = vs_int;
    x_d         = x_q;
    y_d         = y_q;
    line_w_d    = line_w_q;
    width_d     = width_q;
    height_d    = height_q;
    ref_w_d     = ref_w_q;
    ref_h_d     = ref_h_q;
    wd_d        = wd_q;
    sync_d      = sync_q;
    fs_pend_d   = fs_pend_q;
    state_d     = state_q;
    pend_d      = pend_q;
    pend_mode_d = pend_mode_q;
    mode_d      = mode_q;
    ack_d       = 1'b0;

    // Column counter: restarts on each de rising edge, saturates at all-ones
    if (de_rise) begin
      x_d = '0;
    end else if (in_de && (x_q != '1)) begin
      x_d = x_q + 1'b1;
    end
    if (de_fall) begin
      line_w_d = x_len;
    end

    // Row counter: vs_rise takes priority over a coincident line end
    if (vs_rise) begin
      y_d = '0;
    end else if (de_fall && (y_q != '1)) begin
      y_d = y_q + 1'b1;
    end

    // Strobes stay quiet until the first frame boundary after reset
    ls_d = de_rise & (sync_q | vs_rise);
    fs_d = de_rise & (fs_pend_q | vs_rise);
    if (vs_rise) begin
      sync_d = 1'b1;
    end
    if (vs_rise && !de_rise) begin
      fs_pend_d = 1'b1;
    end else if (de_rise) begin
      fs_pend_d = 1'b0;
    end

    if (vs_rise) begin
      wd_d     = '0;
      width_d  = line_w_q;
      height_d = y_q;
      unique case (state_q)
        ST_LOST: state_d = ST_MEASURE;
        ST_MEASURE: begin
          if ((line_w_q != '0) && (y_q != '0)) begin
            ref_w_d = line_w_q;
            ref_h_d = y_q;
            state_d = ST_CONFIRM;
          end
        end
        ST_CONFIRM: begin
          if (dims_match) begin
            state_d = ST_LOCKED;
          end else begin
            ref_w_d = line_w_q;
            ref_h_d = y_q;
          end
        end
        ST_LOCKED: begin
          if (!dims_match) begin
            ref_w_d = line_w_q;
            ref_h_d = y_q;
            state_d = ST_CONFIRM;
          end
        end
        default: state_d = ST_LOST;
      endcase
    end else begin
      if (!wd_expired) begin
        wd_d = wd_q + 1'b1;
      end else begin
        state_d  = ST_LOST;
        width_d  = '0;
        height_d = '0;
      end
    end

    // A request arriving on the boundary cycle wins over an older pending one
    if (vs_rise && (pend_q || mode_req_valid)) begin
      mode_d = mode_req_valid ? mode_req : pend_mode_q;
      ack_d  = 1'b1;
      pend_d = 1'b0;
    end else if (mode_req_valid) begin
      pend_d      = 1'b1;
      pend_mode_d = mode_req;
    end
  end

  // State registers, all cleared asynchronously
  always_ff @(posedge hdmi_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_LOST;
      de_q        <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      vs_int_q    <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      line_w_q    <= '0;
      width_q     <= '0;
      height_q    <= '0;
      ref_w_q     <= '0;
      ref_h_q     <= '0;
      wd_q        <= '0;
      sync_q      <= 1'b0;
      fs_pend_q   <= 1'b0;
      fs_q        <= 1'b0;
      ls_q        <= 1'b0;
      pend_q      <= 1'b0;
      pend_mode_q <= '0;
      mode_q      <= '0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      de_q        <= de_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      vs_int_q    <= vs_int_d;
      x_q         <= x_d;
      y_q         <= y_d;
      line_w_q    <= line_w_d;
      width_q     <= width_d;
      height_q    <= height_d;
      ref_w_q     <= ref_w_d;
      ref_h_q     <= ref_h_d;
      wd_q        <= wd_d;
      sync_q      <= sync_d;
      fs_pend_q   <= fs_pend_d;
      fs_q        <= fs_d;
      ls_q        <= ls_d;
      pend_q      <= pend_d;
      pend_mode_q <= pend_mode_d;
      mode_q      <= mode_d;
      ack_q       <= ack_d;
    end
  end

  assign out_de      = de_q;
  assign out_hs      = hs_q;
  assign out_vs      = vs_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;
  assign width       = width_q;
  assign height      = height_q;
  assign locked      = (state_q == ST_LOCKED);
  assign sel         = (state_q == ST_LOCKED) ? mode_q : 2'b00;
  assign mode_ack    = ack_q;

endmodule
